// File: rtl/ctrl_sequencer_p.sv
`default_nettype none
// ============================================================================
//  Module   : ctrl_sequencer_p
//  Purpose  : Multicycle control sequencer for the MIPS-subset datapath.
//             Fetch/decode with programmable wait counts, ADD/SUB/AND/ADDI/
//             ADDIU execution, and an exception path (EPC save, vector
//             read, PC load) for overflow and unknown instructions.
//  Revision : 1.0  initial release
// ============================================================================
module ctrl_sequencer_p #(
  parameter int unsigned MEM_WAIT    = 2,
  parameter int unsigned DECODE_WAIT = 2,
  parameter bit          ENABLE_OVF  = 1'b1,
  parameter logic [2:0]  EXC_IORD    = 3'd3,
  parameter logic [2:0]  EXC_PCSRC   = 3'd4
) (
  input  logic       clk,
  input  logic       reset_in,
  input  logic [5:0] OPCODE,
  input  logic [5:0] FUNCT,
  input  logic       O,
  output logic [2:0] ALUop,
  output logic [1:0] ALUsrcA,
  output logic [2:0] ALUsrcB,
  output logic [2:0] PCsrc,
  output logic [2:0] IorD,
  output logic [1:0] RegDst,
  output logic [2:0] MemToReg,
  output logic [1:0] EXCPcontrol,
  output logic       PCwrite,
  output logic       IrWrite,
  output logic       MDRwrite,
  output logic       Awrite,
  output logic       Bwrite,
  output logic       ALUoutCtrl,
  output logic       RegWrite,
  output logic       EPCcontrol,
  output logic       MEMwrite,
  output logic       reset_out,
  output logic [4:0] state_dbg
);

  typedef enum logic [4:0] {
    ST_RESET       = 5'd0,
    ST_FETCH_WAIT  = 5'd1,
    ST_FETCH_LATCH = 5'd2,
    ST_DECODE0     = 5'd3,
    ST_DECODE1     = 5'd4,
    ST_EXEC        = 5'd5,
    ST_ALU_LATCH   = 5'd6,
    ST_WB          = 5'd7,
    ST_EXC_EPC     = 5'd8,
    ST_EXC_READ    = 5'd9,
    ST_EXC_LATCH   = 5'd10,
    ST_EXC_JUMP    = 5'd11
  } state_t;

  typedef enum logic [2:0] {
    OP_ADD   = 3'd0,
    OP_SUB   = 3'd1,
    OP_AND   = 3'd2,
    OP_ADDI  = 3'd3,
    OP_ADDIU = 3'd4
  } op_t;

  typedef struct packed {
    logic [2:0] alu_op;
    logic [1:0] alu_src_a;
    logic [2:0] alu_src_b;
    logic [2:0] pc_src;
    logic [2:0] iord;
    logic [1:0] reg_dst;
    logic [2:0] mem_to_reg;
    logic [1:0] excp;
    logic       pc_write;
    logic       ir_write;
    logic       mdr_write;
    logic       a_write;
    logic       b_write;
    logic       alu_out;
    logic       reg_write;
    logic       epc;
    logic       mem_write;
    logic       reset_out;
  } ctrl_t;

  localparam logic [5:0] c_MEM_WAIT_CNT    = MEM_WAIT[5:0];
  localparam logic [5:0] c_DECODE_WAIT_CNT = DECODE_WAIT[5:0];

  state_t     r_state;
  state_t     w_state_nxt;
  logic [5:0] r_cnt;
  logic [5:0] w_cnt_nxt;
  op_t        r_op;
  op_t        w_op_nxt;
  logic       r_cause;
  logic       w_cause_nxt;
  ctrl_t      r_ctrl;
  logic       w_dec_valid;
  op_t        w_dec_op;
  logic       w_trap;

  // Control word for a given state; outputs depend only on state, op and cause.
  function automatic ctrl_t f_decode(input state_t s, input op_t op, input logic cause);
    ctrl_t c;
    logic  is_i;
    c    = '0;
    is_i = (op == OP_ADDI) || (op == OP_ADDIU);
    case (s)
      ST_RESET: begin
        c.reg_write  = 1'b1;
        c.reg_dst    = 2'd3;
        c.mem_to_reg = 3'd4;
        c.reset_out  = 1'b1;
      end
      ST_FETCH_WAIT, ST_FETCH_LATCH: begin
        c.alu_src_b = 3'd1;
        c.alu_op    = 3'd1;
        c.pc_src    = 3'd2;
        c.iord      = 3'd0;
        c.pc_write  = (s == ST_FETCH_LATCH);
        c.ir_write  = (s == ST_FETCH_LATCH);
      end
      ST_DECODE0, ST_DECODE1: begin
        c.alu_src_b = 3'd3;
        c.alu_op    = 3'd1;
        c.a_write   = (s == ST_DECODE1);
        c.b_write   = (s == ST_DECODE1);
        c.alu_out   = (s == ST_DECODE1);
      end
      ST_EXEC, ST_ALU_LATCH: begin
        c.alu_src_a = 2'd2;
        c.alu_src_b = is_i ? 3'd3 : 3'd0;
        case (op)
          OP_SUB:  c.alu_op = 3'd2;
          OP_AND:  c.alu_op = 3'd3;
          default: c.alu_op = 3'd1;
        endcase
        c.alu_out = (s == ST_ALU_LATCH);
      end
      ST_WB: begin
        c.reg_write  = 1'b1;
        c.mem_to_reg = 3'd6;
        c.reg_dst    = is_i ? 2'd0 : 2'd1;
      end
      ST_EXC_EPC: begin
        c.alu_src_a = 2'd0;
        c.alu_src_b = 3'd1;
        c.alu_op    = 3'd2;
        c.epc       = 1'b1;
        c.excp      = {1'b0, cause};
      end
      ST_EXC_READ, ST_EXC_LATCH: begin
        c.iord      = EXC_IORD;
        c.mdr_write = (s == ST_EXC_LATCH);
        c.excp      = {1'b0, cause};
      end
      ST_EXC_JUMP: begin
        c.pc_src   = EXC_PCSRC;
        c.pc_write = 1'b1;
        c.excp     = {1'b0, cause};
      end
      default: c = '0;
    endcase
    return c;
  endfunction

  // Instruction dispatch decode from the live IR fields.
  always_comb begin
    w_dec_valid = 1'b1;
    w_dec_op    = OP_ADD;
    if (OPCODE == 6'h00) begin
      case (FUNCT)
        6'h20:   w_dec_op = OP_ADD;
        6'h22:   w_dec_op = OP_SUB;
        6'h24:   w_dec_op = OP_AND;
        default: w_dec_valid = 1'b0;
      endcase
    end else if (OPCODE == 6'h08) begin
      w_dec_op = OP_ADDI;
    end else if (OPCODE == 6'h09) begin
      w_dec_op = OP_ADDIU;
    end else begin
      w_dec_valid = 1'b0;
    end
  end

  // ADDIU never traps; the other arithmetic ops trap on overflow when enabled.
  assign w_trap = ENABLE_OVF && O &&
                  ((r_op == OP_ADD) || (r_op == OP_SUB) || (r_op == OP_ADDI));

  // Next-state, wait counter, latched op and cause.
  always_comb begin
    w_state_nxt = ST_RESET;
    w_cnt_nxt   = '0;
    w_op_nxt    = r_op;
    w_cause_nxt = r_cause;
    case (r_state)
      ST_RESET:       w_state_nxt = ST_FETCH_WAIT;
      ST_FETCH_WAIT: begin
        if (r_cnt == c_MEM_WAIT_CNT) begin
          w_state_nxt = ST_FETCH_LATCH;
        end else begin
          w_state_nxt = ST_FETCH_WAIT;
          w_cnt_nxt   = r_cnt + 6'd1;
        end
      end
      ST_FETCH_LATCH: w_state_nxt = ST_DECODE0;
      ST_DECODE0:     w_state_nxt = ST_DECODE1;
      ST_DECODE1: begin
        if (r_cnt != c_DECODE_WAIT_CNT) begin
          w_state_nxt = ST_DECODE1;
          w_cnt_nxt   = r_cnt + 6'd1;
        end else if (w_dec_valid) begin
          w_state_nxt = ST_EXEC;
          w_op_nxt    = w_dec_op;
        end else begin
          w_state_nxt = ST_EXC_EPC;
          w_cause_nxt = 1'b0;
        end
      end
      ST_EXEC:        w_state_nxt = ST_ALU_LATCH;
      ST_ALU_LATCH: begin
        if (w_trap) begin
          w_state_nxt = ST_EXC_EPC;
          w_cause_nxt = 1'b1;
        end else begin
          w_state_nxt = ST_WB;
        end
      end
      ST_WB:          w_state_nxt = ST_FETCH_WAIT;
      ST_EXC_EPC:     w_state_nxt = ST_EXC_READ;
      ST_EXC_READ: begin
        if (r_cnt == c_MEM_WAIT_CNT) begin
          w_state_nxt = ST_EXC_LATCH;
        end else begin
          w_state_nxt = ST_EXC_READ;
          w_cnt_nxt   = r_cnt + 6'd1;
        end
      end
      ST_EXC_LATCH:   w_state_nxt = ST_EXC_JUMP;
      ST_EXC_JUMP:    w_state_nxt = ST_FETCH_WAIT;
      default:        w_state_nxt = ST_RESET;
    endcase
  end

  // State register with registered control word decoded from the next state.
  always_ff @(posedge clk or posedge reset_in) begin
    if (reset_in) begin
      r_state <= ST_RESET;
      r_cnt   <= '0;
      r_op    <= OP_ADD;
      r_cause <= 1'b0;
      r_ctrl  <= f_decode(ST_RESET, OP_ADD, 1'b0);
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_op    <= w_op_nxt;
      r_cause <= w_cause_nxt;
      r_ctrl  <= f_decode(w_state_nxt, w_op_nxt, w_cause_nxt);
    end
  end

  assign ALUop       = r_ctrl.alu_op;
  assign ALUsrcA     = r_ctrl.alu_src_a;
  assign ALUsrcB     = r_ctrl.alu_src_b;
  assign PCsrc       = r_ctrl.pc_src;
  assign IorD        = r_ctrl.iord;
  assign RegDst      = r_ctrl.reg_dst;
  assign MemToReg    = r_ctrl.mem_to_reg;
  assign EXCPcontrol = r_ctrl.excp;
  assign PCwrite     = r_ctrl.pc_write;
  assign IrWrite     = r_ctrl.ir_write;
  assign MDRwrite    = r_ctrl.mdr_write;
  assign Awrite      = r_ctrl.a_write;
  assign Bwrite      = r_ctrl.b_write;
  assign ALUoutCtrl  = r_ctrl.alu_out;
  assign RegWrite    = r_ctrl.reg_write;
  assign EPCcontrol  = r_ctrl.epc;
  assign MEMwrite    = r_ctrl.mem_write;
  assign reset_out   = r_ctrl.reset_out;
  assign state_dbg   = r_state;

endmodule
`default_nettype wire

// File: tb/tb_ctrl_sequencer_p.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ctrl_sequencer_p
//  Purpose  : Directed bench for ctrl_sequencer_p. DUT A uses the default
//             waits with overflow traps; DUT B uses zero waits and no traps.
//  Revision : 1.0  initial release
// ============================================================================
module tb_ctrl_sequencer_p;

  localparam logic [4:0] S_RST = 5'd0,  S_FW = 5'd1,  S_FL = 5'd2,  S_D0 = 5'd3;
  localparam logic [4:0] S_D1  = 5'd4,  S_EX = 5'd5,  S_AL = 5'd6,  S_WB = 5'd7;
  localparam logic [4:0] S_EE  = 5'd8,  S_ER = 5'd9,  S_EL = 5'd10, S_EJ = 5'd11;

  logic       clk = 1'b0;
  logic       rst_a = 1'b1;
  logic       rst_b = 1'b1;
  logic [5:0] opcode = 6'h00;
  logic [5:0] funct = 6'h20;
  logic       ovf = 1'b0;
  logic       sel_b = 1'b0;

  int checks = 0;
  int errors = 0;
  int cnt_pcw, cnt_irw, cnt_aw, cnt_rw, cnt_epc, cnt_mdr;
  logic [4:0] exp_q[$];

  wire [2:0] aluop_a, srcb_a, pcsrc_a, iord_a, m2r_a, aluop_b, srcb_b, pcsrc_b, iord_b, m2r_b;
  wire [1:0] srca_a, regdst_a, excp_a, srca_b, regdst_b, excp_b;
  wire       pcw_a, irw_a, mdrw_a, aw_a, bw_a, aluo_a, rw_a, epc_a, memw_a, rsto_a;
  wire       pcw_b, irw_b, mdrw_b, aw_b, bw_b, aluo_b, rw_b, epc_b, memw_b, rsto_b;
  wire [4:0] st_a, st_b;

  ctrl_sequencer_p dut_a (
    .clk(clk), .reset_in(rst_a), .OPCODE(opcode), .FUNCT(funct), .O(ovf),
    .ALUop(aluop_a), .ALUsrcA(srca_a), .ALUsrcB(srcb_a), .PCsrc(pcsrc_a), .IorD(iord_a),
    .RegDst(regdst_a), .MemToReg(m2r_a), .EXCPcontrol(excp_a), .PCwrite(pcw_a),
    .IrWrite(irw_a), .MDRwrite(mdrw_a), .Awrite(aw_a), .Bwrite(bw_a), .ALUoutCtrl(aluo_a),
    .RegWrite(rw_a), .EPCcontrol(epc_a), .MEMwrite(memw_a), .reset_out(rsto_a),
    .state_dbg(st_a)
  );

  ctrl_sequencer_p #(.MEM_WAIT(0), .DECODE_WAIT(0), .ENABLE_OVF(1'b0)) dut_b (
    .clk(clk), .reset_in(rst_b), .OPCODE(opcode), .FUNCT(funct), .O(ovf),
    .ALUop(aluop_b), .ALUsrcA(srca_b), .ALUsrcB(srcb_b), .PCsrc(pcsrc_b), .IorD(iord_b),
    .RegDst(regdst_b), .MemToReg(m2r_b), .EXCPcontrol(excp_b), .PCwrite(pcw_b),
    .IrWrite(irw_b), .MDRwrite(mdrw_b), .Awrite(aw_b), .Bwrite(bw_b), .ALUoutCtrl(aluo_b),
    .RegWrite(rw_b), .EPCcontrol(epc_b), .MEMwrite(memw_b), .reset_out(rsto_b),
    .state_dbg(st_b)
  );

  wire [4:0] o_st     = sel_b ? st_b     : st_a;
  wire [2:0] o_aluop  = sel_b ? aluop_b  : aluop_a;
  wire [1:0] o_srca   = sel_b ? srca_b   : srca_a;
  wire [2:0] o_srcb   = sel_b ? srcb_b   : srcb_a;
  wire [2:0] o_pcsrc  = sel_b ? pcsrc_b  : pcsrc_a;
  wire [2:0] o_iord   = sel_b ? iord_b   : iord_a;
  wire [1:0] o_regdst = sel_b ? regdst_b : regdst_a;
  wire [2:0] o_m2r    = sel_b ? m2r_b    : m2r_a;
  wire [1:0] o_excp   = sel_b ? excp_b   : excp_a;
  wire       o_pcw    = sel_b ? pcw_b    : pcw_a;
  wire       o_irw    = sel_b ? irw_b    : irw_a;
  wire       o_mdrw   = sel_b ? mdrw_b   : mdrw_a;
  wire       o_aw     = sel_b ? aw_b     : aw_a;
  wire       o_rw     = sel_b ? rw_b     : rw_a;
  wire       o_epc    = sel_b ? epc_b    : epc_a;
  wire       o_memw   = sel_b ? memw_b   : memw_a;
  wire       o_rsto   = sel_b ? rsto_b   : rsto_a;

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_state"},    o_st,     S_RST);
    check({tag, "_regwrite"}, o_rw,     1);
    check({tag, "_regdst"},   o_regdst, 3);
    check({tag, "_memtoreg"}, o_m2r,    4);
    check({tag, "_resetout"}, o_rsto,   1);
    check({tag, "_pcwrite"},  o_pcw,    0);
  endtask

  // Walks exp_q one cycle per falling edge, checking state and key outputs.
  task automatic run_seq(input logic [2:0] ex_aluop, input logic [2:0] ex_srcb,
                         input logic [1:0] wb_regdst, input logic [1:0] exc_cause);
    cnt_pcw = 0; cnt_irw = 0; cnt_aw = 0; cnt_rw = 0; cnt_epc = 0; cnt_mdr = 0;
    foreach (exp_q[i]) begin
      @(negedge clk);
      check($sformatf("state_c%0d", i), o_st, exp_q[i]);
      check("memwrite", o_memw, 0);
      cnt_pcw += int'(o_pcw);
      cnt_irw += int'(o_irw);
      cnt_aw  += int'(o_aw);
      cnt_rw  += int'(o_rw);
      cnt_epc += int'(o_epc);
      cnt_mdr += int'(o_mdrw);
      if (exp_q[i] == S_FW) begin
        check("fw_pcsrc", o_pcsrc, 2);
        check("fw_aluop", o_aluop, 1);
      end
      if (exp_q[i] == S_EX) begin
        check("ex_aluop", o_aluop, ex_aluop);
        check("ex_srca",  o_srca,  2);
        check("ex_srcb",  o_srcb,  ex_srcb);
        opcode = 6'h3F;
        funct  = 6'h3F;
      end
      if (exp_q[i] == S_WB) begin
        check("wb_m2r",    o_m2r,    6);
        check("wb_regdst", o_regdst, wb_regdst);
        check("wb_excp",   o_excp,   0);
      end
      if (exp_q[i] == S_EE) begin
        check("ee_aluop", o_aluop, 2);
        check("ee_srcb",  o_srcb,  1);
        check("ee_excp",  o_excp,  exc_cause);
      end
      if (exp_q[i] == S_ER) begin
        check("er_iord", o_iord, 3);
        check("er_excp", o_excp, exc_cause);
      end
      if (exp_q[i] == S_EJ) begin
        check("ej_pcsrc", o_pcsrc, 4);
        check("ej_excp",  o_excp,  exc_cause);
      end
    end
  endtask

  initial begin
    // T1: reset values, release, then async reset mid-cycle
    @(negedge clk);
    check_reset_outputs("t1_rst");
    rst_a = 1'b0;
    @(negedge clk);
    check("t1_fw_state", o_st, S_FW);
    #2 rst_a = 1'b1;
    #1 check_reset_outputs("t1_async");
    @(negedge clk);
    rst_a = 1'b0;

    // T2: ADD without overflow
    opcode = 6'h00; funct = 6'h20; ovf = 1'b0;
    exp_q = '{S_FW, S_FW, S_FW, S_FL, S_D0, S_D1, S_D1, S_D1, S_EX, S_AL, S_WB};
    run_seq(3'd1, 3'd0, 2'd1, 2'd0);
    check("t2_pcw", cnt_pcw, 1);
    check("t2_irw", cnt_irw, 1);
    check("t2_aw",  cnt_aw,  3);
    check("t2_rw",  cnt_rw,  1);
    check("t2_epc", cnt_epc, 0);

    // T3: ADDI with overflow traps
    opcode = 6'h08; funct = 6'h00; ovf = 1'b1;
    exp_q = '{S_FW, S_FW, S_FW, S_FL, S_D0, S_D1, S_D1, S_D1, S_EX, S_AL,
              S_EE, S_ER, S_ER, S_ER, S_EL, S_EJ};
    run_seq(3'd1, 3'd3, 2'd0, 2'd1);
    check("t3_rw",  cnt_rw,  0);
    check("t3_epc", cnt_epc, 1);
    check("t3_mdr", cnt_mdr, 1);
    check("t3_pcw", cnt_pcw, 2);

    // T4b: ADDIU with overflow completes normally
    opcode = 6'h09; funct = 6'h00; ovf = 1'b1;
    exp_q = '{S_FW, S_FW, S_FW, S_FL, S_D0, S_D1, S_D1, S_D1, S_EX, S_AL, S_WB};
    run_seq(3'd1, 3'd3, 2'd0, 2'd0);
    check("t4b_rw",  cnt_rw,  1);
    check("t4b_epc", cnt_epc, 0);

    // AND with overflow flag set never traps
    opcode = 6'h00; funct = 6'h24; ovf = 1'b1;
    exp_q = '{S_FW, S_FW, S_FW, S_FL, S_D0, S_D1, S_D1, S_D1, S_EX, S_AL, S_WB};
    run_seq(3'd3, 3'd0, 2'd1, 2'd0);
    check("and_rw", cnt_rw, 1);

    // T4a: unknown opcode goes straight to the exception path
    opcode = 6'h3F; funct = 6'h20; ovf = 1'b0;
    exp_q = '{S_FW, S_FW, S_FW, S_FL, S_D0, S_D1, S_D1, S_D1,
              S_EE, S_ER, S_ER, S_ER, S_EL, S_EJ};
    run_seq(3'd1, 3'd0, 2'd0, 2'd0);
    check("t4a_rw",  cnt_rw,  0);
    check("t4a_epc", cnt_epc, 1);

    // T5: SUB overflow trap aborted by reset during the vector read
    opcode = 6'h00; funct = 6'h22; ovf = 1'b1;
    exp_q = '{S_FW, S_FW, S_FW, S_FL, S_D0, S_D1, S_D1, S_D1, S_EX, S_AL, S_EE, S_ER};
    run_seq(3'd2, 3'd0, 2'd1, 2'd1);
    #2 rst_a = 1'b1;
    #1 check_reset_outputs("t5_async");
    check("t5_excp", o_excp, 0);
    @(negedge clk);
    rst_a = 1'b0;
    opcode = 6'h00; funct = 6'h20; ovf = 1'b0;
    exp_q = '{S_FW, S_FW, S_FW, S_FL, S_D0, S_D1, S_D1, S_D1, S_EX, S_AL, S_WB, S_FW};
    run_seq(3'd1, 3'd0, 2'd1, 2'd0);
    check("t5_rw",  cnt_rw,  1);
    check("t5_mdr", cnt_mdr, 0);

    // T6: zero waits, overflow traps disabled
    rst_a = 1'b1;
    sel_b = 1'b1;
    #1 check_reset_outputs("t6_rst");
    @(negedge clk);
    rst_b = 1'b0;
    opcode = 6'h00; funct = 6'h22; ovf = 1'b1;
    exp_q = '{S_FW, S_FL, S_D0, S_D1, S_EX, S_AL, S_WB};
    run_seq(3'd2, 3'd0, 2'd1, 2'd0);
    check("t6_sub_rw",  cnt_rw,  1);
    check("t6_sub_epc", cnt_epc, 0);
    check("t6_sub_aw",  cnt_aw,  1);
    opcode = 6'h08; funct = 6'h00; ovf = 1'b1;
    exp_q = '{S_FW, S_FL, S_D0, S_D1, S_EX, S_AL, S_WB, S_FW};
    run_seq(3'd1, 3'd3, 2'd0, 2'd0);
    check("t6_addi_rw",  cnt_rw,  1);
    check("t6_addi_epc", cnt_epc, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
